// File: rtl/microwave_pkg.sv
// Shared definitions for the keypad scanner: FSM states, special key codes, key-map helpers.
package microwave_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  // Digits use codes 0..9; the two function keys sit above them.
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  function automatic logic [1:0] col_of(input logic [2:0] pat);
    if (!pat[0]) return 2'd0;
    else if (!pat[1]) return 2'd1;
    else return 2'd2;
  endfunction

  function automatic logic single_low(input logic [2:0] pat);
    return (pat inside {3'b110, 3'b101, 3'b011});
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/kp_col_sync.sv
// Two-flop synchronizer for the asynchronous keypad column inputs; resets to all-ones (idle).
module kp_col_sync #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x3 keypad scanner: row scan, press/release debounce, one-cycle key strobes.
// Define KEYPAD_AUTOREPEAT_EN to re-strobe a held digit key every REPEAT_CNT cycles.
//   state    | meaning
//   SCAN     | drive rows in turn, sample columns at end of each row period
//   DEBOUNCE | row frozen, waiting for DEBOUNCE_CNT cycles matching the latched pattern
//   HOLD     | key accepted, waiting for all columns high
//   RELEASE  | columns high, waiting for DEBOUNCE_CNT stable cycles before rescanning
module keypad_matrix_scanner
  import microwave_pkg::*;
#(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 1000,
  parameter int REPEAT_CNT   = 50000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row_n,
  input  logic [2:0] col_n,
  output logic [9:0] keypad,
  output logic       start_stop,
  output logic       clear
);

  // The column sample lags the row drive by the synchronizer depth, so a row period needs >= 3 cycles.
  if (SCAN_DIV < 3 || DEBOUNCE_CNT < 1 || REPEAT_CNT < 1) begin : g_param_chk
    $error("keypad_matrix_scanner: SCAN_DIV must be >= 3, DEBOUNCE_CNT and REPEAT_CNT >= 1");
  end

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

  kp_state_t        state, state_nxt;
  logic [1:0]       row_idx, row_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [DEB_W-1:0] deb_cnt, deb_nxt;
  logic [2:0]       col_s, col_lat, lat_nxt;
  logic [3:0]       press_code;
  logic             press_single;
  logic             fire;
  logic [9:0]       keypad_nxt;
  logic             start_stop_nxt, clear_nxt;

  kp_col_sync #(.WIDTH(3)) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d   (col_n),
    .q   (col_s)
  );

  assign row_n        = ~(4'b0001 << row_idx);
  assign press_code   = key_code(row_idx, col_of(col_lat));
  assign press_single = single_low(col_lat);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SCAN;
      row_idx    <= 2'd0;
      div_cnt    <= '0;
      deb_cnt    <= '0;
      col_lat    <= 3'b111;
      keypad     <= '0;
      start_stop <= 1'b0;
      clear      <= 1'b0;
    end else begin
      state      <= state_nxt;
      row_idx    <= row_nxt;
      div_cnt    <= div_nxt;
      deb_cnt    <= deb_nxt;
      col_lat    <= lat_nxt;
      keypad     <= keypad_nxt;
      start_stop <= start_stop_nxt;
      clear      <= clear_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = row_idx;
    div_nxt   = div_cnt;
    deb_nxt   = deb_cnt;
    lat_nxt   = col_lat;
    fire      = 1'b0;
    unique case (state)
      SCAN: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt = '0;
          if (col_s != 3'b111) begin
            lat_nxt   = col_s;
            deb_nxt   = '0;
            state_nxt = DEBOUNCE;
          end else begin
            row_nxt = row_idx + 2'd1;
          end
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end
      DEBOUNCE: begin
        if (col_s != col_lat) begin
          state_nxt = SCAN;
          row_nxt   = row_idx + 2'd1;
          div_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = HOLD;
          deb_nxt   = '0;
          fire      = press_single;
        end else begin
          deb_nxt = deb_cnt + DEB_W'(1);
        end
      end
      HOLD: begin
        if (col_s == 3'b111) begin
          state_nxt = RELEASE;
          deb_nxt   = '0;
        end
      end
      RELEASE: begin
        if (col_s != 3'b111) begin
          state_nxt = HOLD;
          deb_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = SCAN;
          row_nxt   = row_idx + 2'd1;
          div_nxt   = '0;
          deb_nxt   = '0;
        end else begin
          deb_nxt = deb_cnt + DEB_W'(1);
        end
      end
    endcase
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = (REPEAT_CNT > 1) ? $clog2(REPEAT_CNT) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CNT - 1);

  logic [REP_W-1:0] rep_cnt, rep_nxt;
  logic             rep_fire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rep_cnt <= '0;
    else      rep_cnt <= rep_nxt;
  end

  always_comb begin
    rep_nxt  = '0;
    rep_fire = 1'b0;
    if (state == HOLD && press_single && col_s != 3'b111) begin
      if (rep_cnt == REP_LAST) rep_fire = 1'b1;
      else                     rep_nxt  = rep_cnt + REP_W'(1);
    end
  end
`endif

  always_comb begin
    keypad_nxt     = '0;
    start_stop_nxt = 1'b0;
    clear_nxt      = 1'b0;
    if (fire) begin
      if (press_code == KEY_HASH)      start_stop_nxt = 1'b1;
      else if (press_code == KEY_STAR) clear_nxt      = 1'b1;
      else                             keypad_nxt     = 10'b1 << press_code;
    end
`ifdef KEYPAD_AUTOREPEAT_EN
    // Function keys never repeat.
    if (rep_fire && press_code < KEY_STAR) keypad_nxt = 10'b1 << press_code;
`endif
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench: a physical keypad matrix model drives col_n from row_n; strobes are compared to a key table.
module tb_keypad_matrix_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int REP      = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row_n;
  logic [2:0] col_n;
  logic [9:0] keypad;
  logic       start_stop;
  logic       clear;

  logic [2:0]  pressed [4];
  logic [11:0] ev_q[$];
  int          ev_cyc[$];
  int          cyc = 0;
  int          onehot_err = 0;
  int          checks = 0;
  int          failures = 0;
  logic [11:0] mon_v;
  logic [3:0]  e_row, held_row, old_row;
  int          r, c, c2, hold, gap, t0, wait_n, bad;

  keypad_matrix_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEB),
    .REPEAT_CNT   (REP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row_n      (row_n),
    .col_n      (col_n),
    .keypad     (keypad),
    .start_stop (start_stop),
    .clear      (clear)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its column to its row when that row is driven low.
  always_comb begin
    col_n = 3'b111;
    for (int i = 0; i < 4; i++)
      if (!row_n[i]) col_n = col_n & ~pressed[i];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      mon_v = {keypad, start_stop, clear};
      if ($countones(mon_v) > 1) onehot_err++;
      if (mon_v != 12'd0) begin
        ev_q.push_back(mon_v);
        ev_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] key_vec(input int kr, input int kc);
    string map;
    int    d;
    map = "123456789*0#";
    d = int'(map[kr*3 + kc]);
    if (d == 35) return 12'b10;
    if (d == 42) return 12'b01;
    return 12'b1 << (d - 48 + 2);
  endfunction

  function automatic bit allow_repeat(input int kr, input int kc);
`ifdef KEYPAD_AUTOREPEAT_EN
    logic [11:0] v;
    v = key_vec(kr, kc);
    return (v[1:0] == 2'b00);
`else
    return (kr < 0 && kc < 0);
`endif
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_keys();
    for (int i = 0; i < 4; i++) pressed[i] = 3'b000;
  endtask

  task automatic run_press(input string tag, input int r0, input int c0, input int hold_c,
                           input int gap_c, input int exp_n, input logic [11:0] exp_v);
    bit rep_ok;
    rep_ok = allow_repeat(r0, c0);
    ev_q.delete();
    ev_cyc.delete();
    pressed[r0][c0] = 1'b1;
    cycles(hold_c);
    clear_keys();
    cycles(gap_c);
    if (rep_ok) check_eq({tag, "_n"}, 32'(ev_q.size() >= 1), 32'd1);
    else        check_eq({tag, "_n"}, 32'(ev_q.size()), 32'(exp_n));
    if (exp_n > 0) check_eq({tag, "_key"}, 32'((ev_q.size() > 0) ? ev_q[0] : 12'd0), 32'(exp_v));
  endtask

  initial begin
    clear_keys();
    #1;
    check_eq("rst_row", 32'(row_n), 32'(4'b1110));
    check_eq("rst_out", 32'({keypad, start_stop, clear}), 32'd0);
    cycles(3);
    rst = 1'b1;
    ev_q.delete();
    ev_cyc.delete();

    // Idle scan: row index = floor(cycles since reset / SCAN_DIV) mod 4.
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      e_row = 4'b1111;
      e_row[(k / SCAN_DIV) % 4] = 1'b0;
      check_eq("scan_row", 32'(row_n), 32'(e_row));
      @(posedge clk);
      #1;
    end
    check_eq("idle_strobes", 32'(ev_q.size()), 32'd0);

    run_press("digit8", 2, 1, 40, 30, 1, key_vec(2, 1));
    run_press("hash", 3, 2, 45, 30, 1, key_vec(3, 2));
    run_press("star", 3, 0, 45, 30, 1, key_vec(3, 0));

    // Two columns on one row: accepted into HOLD (row frozen) but silent.
    ev_q.delete();
    r = $urandom_range(0, 3);
    c = $urandom_range(0, 2);
    c2 = (c + 1) % 3;
    pressed[r][c] = 1'b1;
    pressed[r][c2] = 1'b1;
    cycles(40);
    held_row = row_n;
    e_row = 4'b1111;
    e_row[r] = 1'b0;
    check_eq("multi_row", 32'(held_row), 32'(e_row));
    cycles(4 * SCAN_DIV * 2);
    check_eq("multi_frozen", 32'(row_n), 32'(held_row));
    clear_keys();
    cycles(30);
    check_eq("multi_n", 32'(ev_q.size()), 32'd0);
    old_row = row_n;
    cycles(SCAN_DIV);
    check_eq("multi_rescan", 32'(row_n != old_row), 32'd1);

    // Contact bounce with a 3-cycle period never holds still long enough to be accepted.
    ev_q.delete();
    r = $urandom_range(0, 3);
    c = $urandom_range(0, 2);
    for (int i = 0; i < 20; i++) begin
      pressed[r][c] = ~pressed[r][c];
      cycles(3);
    end
    clear_keys();
    cycles(30);
    check_eq("bounce_n", 32'(ev_q.size()), 32'd0);
    run_press("resume", r, c, 45, 30, 1, key_vec(r, c));

    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 2);
      hold = $urandom_range(40, 70);
      gap = $urandom_range(25, 40);
      cycles($urandom_range(0, 7));
      run_press($sformatf("rand%0d", i), r, c, hold, gap, 1, key_vec(r, c));
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    ev_q.delete();
    pressed[1][1] = 1'b1;
    wait_n = 0;
    while (ev_q.size() == 0 && wait_n < 60) begin
      cycles(1);
      wait_n++;
    end
    check_eq("rep_first", 32'(ev_q.size()), 32'd1);
    ev_q.delete();
    cycles(100);
    clear_keys();
    cycles(30);
    check_eq("rep_n", 32'(ev_q.size()), 32'd3);
    bad = 0;
    foreach (ev_q[i]) if (ev_q[i] != key_vec(1, 1)) bad++;
    check_eq("rep_key", 32'(bad), 32'd0);
`endif

    // Reset while in HOLD: rows return to row 0 at once, no strobe afterwards.
    ev_q.delete();
    pressed[1][1] = 1'b1;
    wait_n = 0;
    while (ev_q.size() == 0 && wait_n < 60) begin
      cycles(1);
      wait_n++;
    end
    check_eq("rstA_hold", 32'(ev_q.size() > 0), 32'd1);
    cycles(5);
    #3;
    rst = 1'b0;
    #1;
    check_eq("rstA_row", 32'(row_n), 32'(4'b1110));
    check_eq("rstA_out", 32'({keypad, start_stop, clear}), 32'd0);
    clear_keys();
    cycles(3);
    rst = 1'b1;
    ev_q.delete();
    cycles(40);
    check_eq("rstA_none", 32'(ev_q.size()), 32'd0);

    // Reset mid-debounce with the key still held: only a fresh full debounce may strobe.
    pressed[0][2] = 1'b1;
    cycles(6);
    #3;
    rst = 1'b0;
    cycles(3);
    rst = 1'b1;
    t0 = cyc;
    ev_q.delete();
    ev_cyc.delete();
    cycles(40);
    clear_keys();
    cycles(30);
    check_eq("rstB_n", 32'(ev_q.size()), 32'd1);
    check_eq("rstB_key", 32'((ev_q.size() > 0) ? ev_q[0] : 12'd0), 32'(key_vec(0, 2)));
    check_eq("rstB_delay", 32'((ev_cyc.size() > 0) && (ev_cyc[0] - t0 >= DEB)), 32'd1);

    check_eq("onehot", 32'(onehot_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
